pdm_mic_frontend: RTL and testbench
===================================

# pdm_mic_frontend

Multi-channel PDM microphone front end that produces the per-mic PCM samples consumed by the delay-and-sum beamformer. It generates the shared PDM bit clock, captures one 1-bit PDM stream per microphone, and decimates each stream with a 2nd-order CIC filter. It outputs one unsigned BIT_WIDTH sample per mic per output period, with a single-cycle valid strobe.

## Interface
- BIT_WIDTH, 8: PCM sample width per mic (unsigned, offset-binary).
- NUM_MICS, 9: number of PDM data lines (one mic per line).
- CLK_DIV, 4: clk cycles per pdm_clk half-period (≥2).
- DECIM_LOG2, 4: log2 of decimation ratio; DECIM = 2^DECIM_LOG2.
- clk  input  1  system clock; only clock in the block.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable (synchronous level).
- pdm_data  input  NUM_MICS  PDM bit from each mic, bit k = mic k.
- pdm_clk  output  1  PDM bit clock to all mics, registered.
- pcm_data  output  NUM_MICS*BIT_WIDTH  packed samples, mic k at [k*BIT_WIDTH +: BIT_WIDTH].
- pcm_valid  output  1  one-cycle strobe; pcm_data is new and stable until the next strobe.

## Operation
- Reset is asynchronous and active-low. While rst_n = 0: pdm_clk = 0, pcm_valid = 0, pcm_data = 0, and all counters, integrators, comb delays and the warm-up count are cleared.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 while en = 1; pdm_clk toggles on wrap.
  - pdm_clk period = 2*CLK_DIV clk, 50% duty, starting low.
- Capture:
  - pdm_data is registered every clk into pdm_q.
  - Sample tick = the cycle in which pdm_clk is driven 1→0. On a tick, pdm_q is consumed as x ∈ {0,1} per mic.
- CIC, per mic, in modular unsigned arithmetic of width W = 2*DECIM_LOG2+1:
  - On each tick: I1 += x, then I2 += I1, using the updated I1.
  - dec_cnt counts ticks 0..DECIM-1.
  - On the tick where dec_cnt = DECIM-1: C1 = I2 − I2_d; C2 = C1 − C1_d; then I2_d ← I2 and C1_d ← C1.
- Output scaling:
  - C2 lies in 0..DECIM².
  - If 2*DECIM_LOG2 ≥ BIT_WIDTH, out = C2 >> (2*DECIM_LOG2 − BIT_WIDTH), saturated to 2^BIT_WIDTH − 1. Otherwise out = C2 << (BIT_WIDTH − 2*DECIM_LOG2), saturated the same way.
- Warm-up: the first 2 comb outputs after reset or after en rises are discarded. No pcm_valid is issued and pcm_data is not updated for them.
- FSM states:
  - IDLE: en = 0. pdm_clk held 0, datapath cleared. en = 1 → WARM.
  - WARM: running; counts decimation events 0..1. On the 2nd event → RUN.
  - RUN: every decimation event updates pcm_data and pulses pcm_valid.
  - en = 0 from WARM or RUN → IDLE on the next clk edge. pdm_clk is forced 0 in that same edge.
  - A decimation event pending in that same cycle is dropped (no pcm_valid).

## Timing
- pcm_valid is asserted exactly 1 clk after the decimation tick, for exactly 1 clk. pcm_data updates on the same edge.
- Output rate = clk / (2*CLK_DIV*DECIM). Defaults: one sample per 128 clk.
- First pcm_valid after en rises:
  - en high at edge 0; first pdm_clk rise at edge CLK_DIV; first tick at edge 2*CLK_DIV.
  - First valid = edge 3*DECIM*2*CLK_DIV + 1 (the third decimation event). Defaults: edge 385.
- pdm_data input to first influence on an output: 1 clk capture register + tick alignment.
- Integrator wrap-around is intentional; comb differences remain exact modulo 2^W.
- Reset asserted mid-frame takes effect immediately on all outputs. Operation after release is identical to first power-up.

## Test plan
- Clock generation: reset, en = 1, CLK_DIV = 4 → pdm_clk period 8 clk, high 4 / low 4, first rise 4 clk after en sampled high.
- All ones: pdm_data = all 1s continuously → first pcm_valid at the computed edge (385 at defaults); every mic reads 255 (saturated from 256); a strobe every 128 clk thereafter.
- All zeros / alternating: mic 0 all zeros, mic 1 alternating 1,0 per tick, others all ones → steady-state outputs 0, 128, 255 respectively.
- Per-mic isolation: drive ones on mic 4 only → only the mic 4 field equals 255; all other fields equal 0; the packing offset is checked.
- Enable drop: deassert en mid-window → pdm_clk low on the next edge; no further pcm_valid; pcm_data holds its last value. Reassert → two outputs discarded, then correct values with the startup timing above.
- Async reset mid-operation: pulse rst_n low between clk edges → pdm_clk, pcm_valid and pcm_data are 0 immediately; after release with en = 1, the first valid matches the startup timing.

Source files
------------

// File: rtl/pdm_mic_frontend.sv
// ============================================================================
// Module   : pdm_mic_frontend
// Purpose  : Multi-channel PDM microphone front end. It generates the shared
//            PDM bit clock, captures one PDM bit per mic on each falling edge
//            of that clock, and decimates every stream with a 2nd-order CIC
//            filter into unsigned, saturated PCM samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_mic_frontend #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_MICS   = 9,
  parameter int CLK_DIV    = 4,
  parameter int DECIM_LOG2 = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_MICS-1:0]           pdm_data,
  output logic                          pdm_clk,
  output logic [NUM_MICS*BIT_WIDTH-1:0] pcm_data,
  output logic                          pcm_valid
);

  localparam int W     = 2*DECIM_LOG2 + 1;
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                          state;
  state_t                          state_nxt;
  logic                            warm_cnt;
  logic                            warm_cnt_nxt;
  logic [DIV_W-1:0]                div_cnt;
  logic [DECIM_LOG2-1:0]           dec_cnt;
  logic [NUM_MICS-1:0]             pdm_q;
  logic                            evt_q;
  logic                            running;
  logic                            div_wrap;
  logic                            tick;
  logic                            dec_evt;
  logic [NUM_MICS*BIT_WIDTH-1:0]   scaled_all;

  // The datapath only advances once the FSM has left IDLE and en is still high;
  // this keeps the enable edge itself as "edge 0" of the startup timeline.
  assign running  = en && (state != IDLE);
  assign div_wrap = running && (div_cnt == DIV_W'(CLK_DIV-1));
  assign tick     = div_wrap && pdm_clk;
  assign dec_evt  = tick && (dec_cnt == {DECIM_LOG2{1'b1}});

  // FSM state and warm-up counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      warm_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
    end
  end

  // FSM next state: discard the first two decimation events after enable
  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    case (state)
      IDLE: begin
        warm_cnt_nxt = 1'b0;
        if (en) state_nxt = WARM;
      end
      WARM: begin
        if (!en) begin
          state_nxt    = IDLE;
          warm_cnt_nxt = 1'b0;
        end else if (dec_evt) begin
          if (warm_cnt) begin
            state_nxt    = RUN;
            warm_cnt_nxt = 1'b0;
          end else begin
            warm_cnt_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (!en) state_nxt = IDLE;
      end
      default: begin
        state_nxt    = IDLE;
        warm_cnt_nxt = 1'b0;
      end
    endcase
  end

  // PDM clock divider: toggle pdm_clk each time div_cnt wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (!running) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      pdm_clk <= ~pdm_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Capture register for the raw PDM lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pdm_q <= '0;
    else        pdm_q <= pdm_data;
  end

  // Decimation phase counter, advanced once per sample tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dec_cnt <= '0;
    else if (!running) dec_cnt <= '0;
    else if (tick)    dec_cnt <= dec_cnt + DECIM_LOG2'(1);
  end

  for (genvar k = 0; k < NUM_MICS; k++) begin : g_mic
    logic [W-1:0]         i1;
    logic [W-1:0]         i2;
    logic [W-1:0]         i2_d;
    logic [W-1:0]         c1_d;
    logic [W-1:0]         c2_q;
    logic [W-1:0]         i1_nxt;
    logic [W-1:0]         i2_nxt;
    logic [W-1:0]         c1;
    logic [W-1:0]         c2;
    logic [BIT_WIDTH-1:0] scaled;

    // Integrators wrap modulo 2^W; the combs recover exact differences.
    assign i1_nxt = i1 + {{(W-1){1'b0}}, pdm_q[k]};
    assign i2_nxt = i2 + i1_nxt;
    assign c1     = i2_nxt - i2_d;
    assign c2     = c1 - c1_d;

    // Integrators on every tick, comb stage on the decimation tick
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        i1   <= '0;
        i2   <= '0;
        i2_d <= '0;
        c1_d <= '0;
        c2_q <= '0;
      end else if (!running) begin
        i1   <= '0;
        i2   <= '0;
        i2_d <= '0;
        c1_d <= '0;
        c2_q <= '0;
      end else if (tick) begin
        i1 <= i1_nxt;
        i2 <= i2_nxt;
        if (dec_evt) begin
          i2_d <= i2_nxt;
          c1_d <= c1;
          c2_q <= c2;
        end
      end
    end

    // Align the CIC gain (DECIM^2) onto BIT_WIDTH and saturate the top code.
    if (2*DECIM_LOG2 >= BIT_WIDTH) begin : g_shr
      localparam int SR = 2*DECIM_LOG2 - BIT_WIDTH;
      logic [W-1:0] shr;
      assign shr    = c2_q >> SR;
      assign scaled = (|shr[W-1:BIT_WIDTH]) ? {BIT_WIDTH{1'b1}} : shr[BIT_WIDTH-1:0];
    end else begin : g_shl
      localparam int SL = BIT_WIDTH - 2*DECIM_LOG2;
      logic [BIT_WIDTH:0] shl;
      assign shl    = {c2_q, {SL{1'b0}}};
      assign scaled = shl[BIT_WIDTH] ? {BIT_WIDTH{1'b1}} : shl[BIT_WIDTH-1:0];
    end

    assign scaled_all[k*BIT_WIDTH +: BIT_WIDTH] = scaled;
  end

  // Marks a decimation event that should be published on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt_q <= 1'b0;
    else        evt_q <= dec_evt && (state == RUN);
  end

  // Output register: publish samples one clk after the decimation tick;
  // an event still in flight when en drops is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_valid <= 1'b0;
      pcm_data  <= '0;
    end else begin
      pcm_valid <= evt_q && en;
      if (evt_q && en) pcm_data <= scaled_all;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pdm_mic_frontend.sv
// ============================================================================
// Module   : tb_pdm_mic_frontend
// Purpose  : Randomized scoreboard bench for pdm_mic_frontend. Expected PCM
//            samples come from a boxcar-of-boxcar model over the tick history.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdm_mic_frontend;

  localparam int BW    = 8;
  localparam int NM    = 9;
  localparam int CD    = 4;
  localparam int DL    = 4;
  localparam int DECIM = 1 << DL;
  localparam int PER   = 2*CD;
  localparam int MAXV  = (1 << BW) - 1;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [NM-1:0]     pdm_data;
  logic              pdm_clk;
  logic [NM*BW-1:0]  pcm_data;
  logic              pcm_valid;

  typedef struct {
    int           cyc;
    logic [NM*BW-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  logic [NM-1:0]    hist[$];
  logic [NM*BW-1:0] last_exp;
  int               dens[NM];
  int               cyc;
  int               checks;
  int               errors;

  pdm_mic_frontend #(
    .BIT_WIDTH (BW),
    .NUM_MICS  (NM),
    .CLK_DIV   (CD),
    .DECIM_LOG2(DL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pdm_data (pdm_data),
    .pdm_clk  (pdm_clk),
    .pcm_data (pcm_data),
    .pcm_valid(pcm_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // free-running edge counter used for timing stamps
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Second-order CIC == two cascaded DECIM-long boxcars, sampled at tick n.
  function automatic int model_c2(input int mic, input int n);
    int s;
    s = 0;
    for (int k = 0; k < DECIM; k++)
      for (int i = n - k - DECIM + 1; i <= n - k; i++)
        if (i >= 1) s += int'(hist[i-1][mic]);
    return s;
  endfunction

  function automatic int scale(input int c2);
    int v;
    if (2*DL >= BW) v = c2 >> (2*DL - BW);
    else            v = c2 << (BW - 2*DL);
    if (v > MAXV) v = MAXV;
    return v;
  endfunction

  function automatic logic [NM-1:0] gen_word(input int mode, input int n);
    logic [NM-1:0] w;
    w = '0;
    for (int m = 0; m < NM; m++) begin
      case (mode)
        1: w[m] = 1'b1;
        2: w[m] = (m == 0) ? 1'b0 : (m == 1) ? ((n % 2) == 1) : 1'b1;
        3: w[m] = (m == 4);
        default: w[m] = ($urandom_range(0, 99) < dens[m]);
      endcase
    end
    return w;
  endfunction

  // Runs n_edges edges with en high; edge 0 is the one that samples en = 1.
  task automatic run_phase(input int mode, input int n_edges);
    int n;
    exp_t e;
    hist.delete();
    for (int m = 0; m < NM; m++) dens[m] = $urandom_range(0, 100);
    en = 1'b1;
    for (int k = 0; k < n_edges; k++) begin
      @(posedge clk); #1;
      check("pdm_clk", int'(pdm_clk), (k / CD) % 2);
      if (k > 0 && (k % PER) == 0) begin
        n = k / PER;
        if ((n % DECIM) == 0 && (n / DECIM) >= 3) begin
          e.cyc = cyc + 1;
          for (int m = 0; m < NM; m++)
            e.data[m*BW +: BW] = BW'(scale(model_c2(m, n)));
          exp_q.push_back(e);
          last_exp = e.data;
        end
      end
      if ((k % PER) == CD) begin
        n = k / PER + 1;
        pdm_data = gen_word(mode, n);
        hist.push_back(pdm_data);
      end
    end
  endtask

  task automatic drop_enable(input int idle_edges);
    en = 1'b0;
    @(posedge clk); #1;
    check("drop_pdm_clk", int'(pdm_clk), 0);
    for (int k = 0; k < idle_edges; k++) begin
      @(posedge clk); #1;
      pdm_data = NM'($urandom);
      check("idle_pdm_clk", int'(pdm_clk), 0);
    end
    for (int m = 0; m < NM; m++)
      check($sformatf("hold_mic%0d", m), int'(pcm_data[m*BW +: BW]), int'(last_exp[m*BW +: BW]));
  endtask

  // Monitor: pop one expected sample per strobe and compare time and data.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (pcm_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("valid_cycle", cyc, e.cyc);
          for (int m = 0; m < NM; m++)
            check($sformatf("pcm_mic%0d", m), int'(pcm_data[m*BW +: BW]), int'(e.data[m*BW +: BW]));
        end
      end
    end
  end

  initial begin
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    en       = 1'b0;
    pdm_data = '0;
    #2;
    check("rst_pdm_clk", int'(pdm_clk), 0);
    check("rst_valid", int'(pcm_valid), 0);
    check("rst_data_nz", int'(|pcm_data), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_phase(1, 128*5 + 60);
    drop_enable(200);
    run_phase(2, 128*6 + 60);
    drop_enable(150);
    run_phase(3, 128*5 + 60);
    drop_enable(150);
    run_phase(0, 128*8 + 60);

    // asynchronous reset between edges while running
    rst_n = 1'b0;
    #1;
    check("arst_pdm_clk", int'(pdm_clk), 0);
    check("arst_valid", int'(pcm_valid), 0);
    check("arst_data_nz", int'(|pcm_data), 0);
    #2 rst_n = 1'b1;
    last_exp = '0;

    run_phase(0, 128*6 + 60);
    drop_enable(100);
    run_phase(0, 128*5 + 60);
    drop_enable(50);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
